// File: rtl/disp_arbiter.sv
// Shares the two-digit seven-segment display between port 0 and three
// round-robin requesters. Each granted port gets a timed slot, and a blank gap separates consecutive slots.
module disp_arbiter #(
    parameter int HOLD_TICKS = 5000000,
    parameter int GAP_TICKS  = 500000,
    parameter int CNT_W      = $clog2(((HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS) + 1)
) (
    input  logic        clk,
    input  logic        CLR,
    input  logic [3:0]  req,
    input  logic [31:0] data,
    output logic [7:0]  disp_val,
    output logic        blank,
    output logic [3:0]  gnt,
    output logic [1:0]  disp_src,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_TICKS - 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]       r_rr_last, w_rr_nxt;
    logic [7:0]       w_val_nxt;
    logic             w_blank_nxt;
    logic [3:0]       w_gnt_nxt;
    logic [1:0]       w_src_nxt;
    logic             w_busy_nxt;

    logic [1:0]       w_c1, w_c2, w_c3, w_win;
    logic             w_any;
    logic [3:0]       w_src_oh;
    logic             w_refresh;
    logic             w_do_grant;

    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p == 2'd3) ? 2'd1 : p + 2'd1;
    endfunction

    function automatic logic [7:0] sel_byte(input logic [31:0] d, input logic [1:0] p);
        logic [7:0] b;
        case (p)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        return b;
    endfunction

    // Search order after the last winner, wrapping within ports 1..3.
    always_comb begin
        w_c1  = rr_next(r_rr_last);
        w_c2  = rr_next(w_c1);
        w_c3  = rr_next(w_c2);
        w_any = |req[3:1];
        if (req[w_c1])
            w_win = w_c1;
        else if (req[w_c2])
            w_win = w_c2;
        else
            w_win = w_c3;
    end

    // Refresh only when the owning port is the sole requester.
    always_comb begin
        w_src_oh  = 4'b0001 << disp_src;
        w_refresh = (disp_src != 2'd0) && (|(req & w_src_oh))
                    && !(|(req[3:1] & ~w_src_oh[3:1]));
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rr_nxt    = r_rr_last;
        w_val_nxt   = disp_val;
        w_blank_nxt = blank;
        w_gnt_nxt   = '0;
        w_src_nxt   = disp_src;
        w_busy_nxt  = busy;
        w_do_grant  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_do_grant = 1'b1;
                end else begin
                    w_val_nxt   = data[7:0];
                    w_src_nxt   = 2'd0;
                    w_busy_nxt  = 1'b0;
                    w_blank_nxt = 1'b0;
                end
            end
            ST_HOLD: begin
                if (w_refresh) begin
                    w_val_nxt = sel_byte(data, disp_src);
                    w_cnt_nxt = HOLD_LOAD;
                    w_gnt_nxt = w_src_oh;
                    w_rr_nxt  = disp_src;
                end else if (r_cnt == '0) begin
                    w_src_nxt = 2'd0;
                    if (w_any) begin
                        w_state_nxt = ST_GAP;
                        w_blank_nxt = 1'b1;
                        w_val_nxt   = '0;
                        w_cnt_nxt   = GAP_LOAD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_busy_nxt  = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (r_cnt == '0) begin
                    if (w_any) begin
                        w_do_grant = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_blank_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        if (w_do_grant) begin
            w_state_nxt = ST_HOLD;
            w_val_nxt   = sel_byte(data, w_win);
            w_gnt_nxt   = 4'b0001 << w_win;
            w_src_nxt   = w_win;
            w_blank_nxt = 1'b0;
            w_busy_nxt  = 1'b1;
            w_cnt_nxt   = HOLD_LOAD;
            w_rr_nxt    = w_win;
        end
    end

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_rr_last <= 2'd3;
            disp_val  <= '0;
            blank     <= 1'b0;
            gnt       <= '0;
            disp_src  <= 2'd0;
            busy      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rr_last <= w_rr_nxt;
            disp_val  <= w_val_nxt;
            blank     <= w_blank_nxt;
            gnt       <= w_gnt_nxt;
            disp_src  <= w_src_nxt;
            busy      <= w_busy_nxt;
        end
    end

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed bench for disp_arbiter with HOLD_TICKS=8 and GAP_TICKS=2.
// It uses a per-cycle vector table, followed by sequences for round-robin, fairness, refresh and reset mid-GAP.
module tb_disp_arbiter;

    logic        clk;
    logic        CLR;
    logic [3:0]  req;
    logic [31:0] data;
    logic [7:0]  disp_val;
    logic        blank;
    logic [3:0]  gnt;
    logic [1:0]  disp_src;
    logic        busy;

    int checks;
    int failures;

    disp_arbiter #(
        .HOLD_TICKS(8),
        .GAP_TICKS (2)
    ) dut (
        .clk     (clk),
        .CLR     (CLR),
        .req     (req),
        .data    (data),
        .disp_val(disp_val),
        .blank   (blank),
        .gnt     (gnt),
        .disp_src(disp_src),
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [7:0]  val;
        logic        blank;
        logic [3:0]  gnt;
        logic [1:0]  src;
        logic        busy;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic [3:0] r, input logic [31:0] d, input logic [7:0] v,
                                input logic b, input logic [3:0] g, input logic [1:0] s,
                                input logic bz);
        vec_t t;
        t.req = r; t.data = d; t.val = v; t.blank = b; t.gnt = g; t.src = s; t.busy = bz;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Step until a grant pulse shows; count blank cycles and non-zero values seen during blank.
    task automatic wait_gnt(output logic [3:0] g, output int nblank, output int bad_val);
        bit found;
        found   = 1'b0;
        g       = '0;
        nblank  = 0;
        bad_val = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (blank) begin
                nblank++;
                if (disp_val != 8'h00) bad_val++;
            end
            if (gnt != 4'b0000) begin
                g     = gnt;
                found = 1'b1;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            step();
            if (!busy) done = 1'b1;
        end
        chk(name, {31'd0, done}, 32'd1);
    endtask

    task automatic do_reset();
        CLR = 1'b1;
        req = '0;
        step();
        CLR = 1'b0;
    endtask

    initial begin
        logic [3:0] g;
        int nb, bv, n, bad;
        logic [7:0] rr_bytes [3];
        int fair_ports [4];

        checks   = 0;
        failures = 0;
        CLR  = 1'b1;
        req  = '0;
        data = '0;

        vecs[0]  = mk(4'b0000, 32'h0000_003C, 8'h3C, 0, 4'b0000, 2'd0, 0);
        vecs[1]  = mk(4'b0001, 32'h0000_0042, 8'h42, 0, 4'b0000, 2'd0, 0);
        vecs[2]  = mk(4'b0100, 32'h00A5_0011, 8'hA5, 0, 4'b0100, 2'd2, 1);
        for (int i = 3; i <= 9; i++)
            vecs[i] = mk(4'b0000, 32'h00FF_0077, 8'hA5, 0, 4'b0000, 2'd2, 1);
        vecs[10] = mk(4'b0000, 32'h0000_00A5, 8'hA5, 0, 4'b0000, 2'd0, 0);
        vecs[11] = mk(4'b0000, 32'h0000_0077, 8'h77, 0, 4'b0000, 2'd0, 0);

        step();
        step();
        chk("reset_state", {16'd0, disp_val, blank, gnt, disp_src, busy}, 32'd0);
        CLR = 1'b0;

        for (int i = 0; i < NV; i++) begin
            req  = vecs[i].req;
            data = vecs[i].data;
            step();
            chk($sformatf("vec%0d", i), {16'd0, disp_val, blank, gnt, disp_src, busy},
                {16'd0, vecs[i].val, vecs[i].blank, vecs[i].gnt, vecs[i].src, vecs[i].busy});
        end

        // Round-robin: 1, 2, 3 with exactly two blank cycles between slots.
        do_reset();
        rr_bytes[0] = 8'h11; rr_bytes[1] = 8'h22; rr_bytes[2] = 8'h33;
        data = 32'h3322_1100;
        req  = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            wait_gnt(g, nb, bv);
            chk($sformatf("rr_gnt%0d", k), {28'd0, g}, 32'd1 << (k + 1));
            chk($sformatf("rr_val%0d", k), {24'd0, disp_val}, {24'd0, rr_bytes[k]});
            if (k > 0) begin
                chk($sformatf("rr_gap%0d", k), nb, 2);
                chk($sformatf("rr_gapval%0d", k), bv, 0);
            end
            req = req & ~g;
        end
        wait_idle("rr_idle");

        // Fairness: port 1 requests continuously while port 3 is pending.
        fair_ports[0] = 1; fair_ports[1] = 3; fair_ports[2] = 1; fair_ports[3] = 3;
        req = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(g, nb, bv);
            chk($sformatf("fair_gnt%0d", k), {28'd0, g}, 32'd1 << fair_ports[k]);
            if (k > 0) chk($sformatf("fair_gap%0d", k), nb, 2);
        end
        req = '0;
        wait_idle("fair_idle");

        // Refresh of port 1 when the counter is at 3.
        data = 32'h0000_AA00;
        req  = 4'b0010;
        wait_gnt(g, nb, bv);
        chk("ref_gnt", {28'd0, g}, 32'h2);
        req = '0;
        for (int i = 0; i < 4; i++) step();
        req  = 4'b0010;
        data = 32'h0000_1100;
        step();
        chk("ref_pulse", {24'd0, gnt, 2'd0, disp_src}, {24'd0, 4'b0010, 2'd0, 2'd1});
        chk("ref_val", {24'd0, disp_val}, 32'h11);
        req = '0;
        n   = 0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            n++;
            if (!busy) break;
            if (disp_val != 8'h11) bad++;
        end
        chk("ref_hold_len", n, 8);
        chk("ref_hold_val", bad, 0);

        // Refresh ignored when port 2 is also requesting; port 2 follows after the gap.
        data = 32'h0022_AA00;
        req  = 4'b0010;
        wait_gnt(g, nb, bv);
        chk("noref_gnt1", {28'd0, g}, 32'h2);
        req = '0;
        for (int i = 0; i < 4; i++) step();
        req  = 4'b0110;
        data = 32'h0022_1100;
        step();
        chk("noref_pulse", {28'd0, gnt}, 32'h0);
        chk("noref_val", {24'd0, disp_val}, 32'hAA);
        req = 4'b0100;
        wait_gnt(g, nb, bv);
        chk("noref_gnt2", {28'd0, g}, 32'h4);
        chk("noref_gap", nb, 2);
        chk("noref_val2", {24'd0, disp_val}, 32'h22);
        req = '0;
        wait_idle("noref_idle");

        // CLR asserted during GAP clears outputs without a clock edge and restarts the round-robin.
        data = 32'h3322_1100;
        req  = 4'b0010;
        wait_gnt(g, nb, bv);
        chk("clr_gnt1", {28'd0, g}, 32'h2);
        req = 4'b1100;
        n   = 0;
        for (int i = 0; i < 40 && n == 0; i++) begin
            step();
            if (blank) n = 1;
        end
        chk("clr_gap_seen", n, 1);
        #2;
        CLR = 1'b1;
        #1;
        chk("clr_async", {16'd0, disp_val, blank, gnt, disp_src, busy}, 32'd0);
        step();
        CLR = 1'b0;
        req = 4'b1110;
        wait_gnt(g, nb, bv);
        chk("clr_first_gnt", {28'd0, g}, 32'h2);
        chk("clr_no_gap", nb, 0);
        req = '0;
        wait_idle("clr_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
